fifo_p: RTL and testbench
=========================

Name: fifo_p

Overview:
- Store-and-forward packet FIFO for an 8-bit byte stream framed by start-of-packet and end-of-packet flags.
- A packet is forwarded only once it has been received complete, from sop through eop.
- Forwarded packets are sent contiguously at one byte per clock.
- Sits between a bursty packet source and a downstream consumer that needs gap-free packets.

Parameters:
- DW, 8, data width.
- AW, 9, data-buffer address width; buffer depth = 2^AW = 512 words.
- PW, 4, address width of the committed-packet counter / packet-end queue; max 16 committed packets.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din_vld  input  1  input byte valid.
- din_sop  input  1  first byte of packet; qualified by din_vld.
- din_eop  input  1  last byte of packet; qualified by din_vld.
- din  input  DW  input byte.
- dout_vld  output  1  output byte valid.
- dout_sop  output  1  first byte of output packet.
- dout_eop  output  1  last byte of output packet.
- dout  output  DW  output byte.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0.
  - Write pointer, commit pointer, read pointer and packet count 0.
  - Write state IDLE.
- Storage: each word is {sop,eop,data}, DW+2 bits wide, held in a simple dual-port RAM.
- Write state machine, states IDLE and RECV:
  - IDLE, din_vld & din_sop: write word, go to RECV. If din_eop is also set, the packet is one byte; commit immediately and stay in IDLE.
  - IDLE, din_vld without din_sop: byte discarded.
  - RECV, din_vld & !din_sop: write word. If din_eop, commit the packet and go to IDLE.
  - RECV, din_vld & din_sop: the partial packet is discarded (write pointer rewinds to commit pointer). The new byte starts a fresh packet.
  - din_vld=0: nothing written; packet continues.
- Commit: on the edge that samples din_eop:
  - commit pointer is set to write pointer + 1;
  - packet count is incremented.
- Overflow:
  - If a write would make the write pointer equal the read pointer (buffer full), the whole partial packet is dropped.
  - Write pointer rewinds to commit pointer; state goes to IDLE; remaining bytes up to the next sop are ignored.
  - The same drop applies if an eop arrives while the packet count is already 2^PW.
  - Committed packets are never corrupted.
- Read side:
  - Reading starts when packet count > 0 and no packet is currently being read.
  - Once started, reading proceeds one word per cycle until a word with eop is read.
  - Packet count is decremented when the eop word is read.
  - A simultaneous commit and decrement leaves the count unchanged.
- Output timing:
  - All outputs are registered.
  - For a packet committed at edge T while the reader is idle, dout_vld rises after edge T+2, carrying the sop byte. Bytes follow on consecutive cycles with no gaps.
  - dout_sop and dout_eop come from the stored flags, high for exactly one cycle each, coincident with dout_vld.
  - If another packet is committed when dout_eop is output, the next packet's sop word follows on the very next cycle.
  - When idle: dout_vld=dout_sop=dout_eop=0, and dout holds its last value.
- Pointers are AW+1 bits wide to distinguish full from empty; addresses wrap modulo 2^AW.
- Data is forwarded byte-exact, in order, with lengths preserved; there is no length limit other than buffer depth.

Test Plan:
- Reset release, then a 200-byte packet (din 0..199, sop on byte 0, eop on byte 199, continuous vld):
  - dout_vld rises 2 cycles after the eop edge;
  - 200 contiguous bytes 0..199;
  - dout_sop with byte 0, dout_eop with byte 199.
- Six back-to-back packets with 30-cycle gaps:
  - lengths 200, 150, 170, 150, 200, and 150 with data starting at 30;
  - each packet output whole and in order, and packet 6 outputs 30..179;
  - no dout_vld bubbles within a packet.
- Two packets committed while the reader is busy: dout_eop of the first is followed next cycle by dout_sop of the second.
- Malformed input:
  - bytes without a preceding sop are never output;
  - a new sop mid-packet drops the first packet, and only the second is output.
- Overflow, with the reader kept busy with committed packets:
  - a packet that cannot fit is dropped entirely;
  - the following packet, once space frees up, is output intact.
- Reset asserted mid-output: outputs go to 0 immediately and the buffer empties; a packet sent after release is output normally.

Source files
------------

// File: rtl/fifo_p.sv
// Store-and-forward packet FIFO: a {sop,eop,data} stream is buffered until its
// eop arrives, then replayed as a gap-free burst at one byte per clock.
module fifo_p #(
  parameter int DW = 8,
  parameter int AW = 9,
  parameter int PW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          din_vld,
  input  logic          din_sop,
  input  logic          din_eop,
  input  logic [DW-1:0] din,
  output logic          dout_vld,
  output logic          dout_sop,
  output logic          dout_eop,
  output logic [DW-1:0] dout
);

  localparam int WW    = DW + 2;
  localparam int DEPTH = 1 << AW;
  localparam int NPQ   = 1 << PW;

  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] FULL_GAP = {1'b1, {AW{1'b0}}};
  localparam logic [PW:0] CNT_ONE  = {{PW{1'b0}}, 1'b1};
  localparam logic [PW:0] CNT_MAX  = {1'b1, {PW{1'b0}}};
  localparam logic [PW-1:0] PQ_ONE = {{(PW-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } wr_state_e;

  wr_state_e     state_q, state_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   cmt_ptr_q, cmt_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [PW:0]   pkt_cnt_q, pkt_cnt_d;
  logic [PW-1:0] pq_wr_q, pq_wr_d;
  logic [PW-1:0] pq_rd_q, pq_rd_d;
  logic          rd_vld_q, rd_vld_d;
  logic          dout_vld_q, dout_vld_d;
  logic          dout_sop_q, dout_sop_d;
  logic          dout_eop_q, dout_eop_d;
  logic [DW-1:0] dout_q, dout_d;

  logic [WW-1:0] mem [DEPTH];
  logic [AW:0]   end_mem [NPQ];
  logic [WW-1:0] ram_rdata_q;

  logic          wr_en;
  logic          commit;
  logic [AW:0]   wr_addr;
  logic          rd_en;
  logic          rd_last;

  // A sop always restarts at the commit pointer, discarding any partial packet.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    cmt_ptr_d = cmt_ptr_q;
    wr_en     = 1'b0;
    commit    = 1'b0;
    wr_addr   = wr_ptr_q;
    if (din_vld && (din_sop || state_q == RECV)) begin
      wr_addr = din_sop ? cmt_ptr_q : wr_ptr_q;
      if (((wr_addr - rd_ptr_q) == FULL_GAP) || (din_eop && pkt_cnt_q == CNT_MAX)) begin
        wr_ptr_d = cmt_ptr_q;
        state_d  = IDLE;
      end else begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_addr + PTR_ONE;
        if (din_eop) begin
          commit    = 1'b1;
          cmt_ptr_d = wr_addr + PTR_ONE;
          state_d   = IDLE;
        end else begin
          state_d = RECV;
        end
      end
    end
  end

  // The head of the packet-end queue tells the reader where its eop word sits,
  // so the next packet can be fetched on the cycle right after that eop.
  always_comb begin
    rd_en     = (pkt_cnt_q != '0);
    rd_last   = rd_en && (rd_ptr_q == end_mem[pq_rd_q]);
    rd_ptr_d  = rd_en ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    pq_rd_d   = rd_last ? (pq_rd_q + PQ_ONE) : pq_rd_q;
    pq_wr_d   = commit ? (pq_wr_q + PQ_ONE) : pq_wr_q;
    pkt_cnt_d = pkt_cnt_q;
    if (commit && !rd_last) begin
      pkt_cnt_d = pkt_cnt_q + CNT_ONE;
    end else if (!commit && rd_last) begin
      pkt_cnt_d = pkt_cnt_q - CNT_ONE;
    end
  end

  always_comb begin
    rd_vld_d   = rd_en;
    dout_vld_d = rd_vld_q;
    dout_sop_d = rd_vld_q & ram_rdata_q[WW-1];
    dout_eop_d = rd_vld_q & ram_rdata_q[WW-2];
    dout_d     = rd_vld_q ? ram_rdata_q[DW-1:0] : dout_q;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr[AW-1:0]] <= {din_sop, din_eop, din};
    end
    if (rd_en) begin
      ram_rdata_q <= mem[rd_ptr_q[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      end_mem[pq_wr_q] <= wr_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      cmt_ptr_q  <= '0;
      rd_ptr_q   <= '0;
      pkt_cnt_q  <= '0;
      pq_wr_q    <= '0;
      pq_rd_q    <= '0;
      rd_vld_q   <= 1'b0;
      dout_vld_q <= 1'b0;
      dout_sop_q <= 1'b0;
      dout_eop_q <= 1'b0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      cmt_ptr_q  <= cmt_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pkt_cnt_q  <= pkt_cnt_d;
      pq_wr_q    <= pq_wr_d;
      pq_rd_q    <= pq_rd_d;
      rd_vld_q   <= rd_vld_d;
      dout_vld_q <= dout_vld_d;
      dout_sop_q <= dout_sop_d;
      dout_eop_q <= dout_eop_d;
      dout_q     <= dout_d;
    end
  end

  assign dout_vld = dout_vld_q;
  assign dout_sop = dout_sop_q;
  assign dout_eop = dout_eop_q;
  assign dout     = dout_q;

endmodule

// File: tb/tb_fifo_p.sv
// Directed bench for fifo_p: every kept packet is queued as expected words when
// driven, and each output word is popped and compared on the falling edge.
module tb_fifo_p;

  logic       clk;
  logic       rst_n;
  logic       din_vld;
  logic       din_sop;
  logic       din_eop;
  logic [7:0] din;
  logic       dout_vld;
  logic       dout_sop;
  logic       dout_eop;
  logic [7:0] dout;

  int checks = 0;
  int errors = 0;
  logic [9:0] sb[$];
  logic       in_pkt;
  logic [7:0] last_dout;

  int lens[6]   = '{200, 150, 170, 150, 200, 150};
  int starts[6] = '{0, 100, 50, 7, 200, 30};

  fifo_p dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din_vld  (din_vld),
    .din_sop  (din_sop),
    .din_eop  (din_eop),
    .din      (din),
    .dout_vld (dout_vld),
    .dout_sop (dout_sop),
    .dout_eop (dout_eop),
    .dout     (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic s, input logic e, input logic [7:0] d);
    din_vld = v;
    din_sop = s;
    din_eop = e;
    din     = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_pkt(input int start, input int len, input bit keep, input bit fin);
    logic       s;
    logic       e;
    logic [7:0] d;
    for (int i = 0; i < len; i++) begin
      s = (i == 0);
      e = fin && (i == len - 1);
      d = 8'(start + i);
      if (keep) sb.push_back({s, e, d});
      step(1'b1, s, e, d);
    end
    din_vld = 1'b0;
    din_sop = 1'b0;
    din_eop = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int maxc);
    for (int k = 0; k < maxc && sb.size() != 0; k++) @(negedge clk);
    #1;
    chk(tag, 32'(sb.size()), 0);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      in_pkt    <= 1'b0;
      last_dout <= 8'h00;
    end else begin
      if (in_pkt) chk("no_bubble", 32'(dout_vld), 1);
      if (dout_vld) begin
        chk("out_expected", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) chk("out_word", 32'({dout_sop, dout_eop, dout}), 32'(sb.pop_front()));
        if (dout_eop) in_pkt <= 1'b0;
        else if (dout_sop) in_pkt <= 1'b1;
        last_dout <= dout;
      end else begin
        chk("idle_flags", 32'({dout_sop, dout_eop}), 0);
        chk("idle_hold", 32'(dout), 32'(last_dout));
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    din_vld = 1'b0;
    din_sop = 1'b0;
    din_eop = 1'b0;
    din     = 8'h00;
    #12;
    chk("reset_outputs", 32'({dout_vld, dout_sop, dout_eop, dout}), 0);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 200-byte packet and its commit-to-output latency
    send_pkt(0, 200, 1'b1, 1'b1);
    @(negedge clk);
    chk("lat_t0_vld", 32'(dout_vld), 0);
    @(negedge clk);
    chk("lat_t1_vld", 32'(dout_vld), 0);
    @(negedge clk);
    chk("lat_t2_vld_sop", 32'({dout_vld, dout_sop, dout}), 32'({1'b1, 1'b1, 8'h00}));
    wait_drain("pkt200_drain", 400);

    // six packets separated by 30 idle cycles
    for (int p = 0; p < 6; p++) begin
      send_pkt(starts[p], lens[p], 1'b1, 1'b1);
      idle(30);
    end
    wait_drain("six_drain", 600);

    // second packet committed while the first is still streaming out
    send_pkt(60, 40, 1'b1, 1'b1);
    send_pkt(120, 10, 1'b1, 1'b1);
    for (int k = 0; k < 200 && !(dout_vld && dout_eop); k++) @(negedge clk);
    chk("b2b_first_eop", 32'({dout_vld, dout_eop, dout}), 32'({1'b1, 1'b1, 8'(60 + 39)}));
    @(negedge clk);
    chk("b2b_next_sop", 32'({dout_vld, dout_sop, dout}), 32'({1'b1, 1'b1, 8'(120)}));
    wait_drain("b2b_drain", 100);

    // malformed input: orphan bytes, restarted packet, single-byte packet
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0, 8'(8'hA0 + k));
    send_pkt(80, 12, 1'b0, 1'b0);
    send_pkt(150, 15, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 8'hEE);
    step(1'b1, 1'b0, 1'b1, 8'hEF);
    sb.push_back({1'b1, 1'b1, 8'h5A});
    step(1'b1, 1'b1, 1'b1, 8'h5A);
    idle(2);
    wait_drain("malformed_drain", 100);

    // overflow: oversized packet dropped behind a committed one
    send_pkt(10, 100, 1'b1, 1'b1);
    send_pkt(0, 600, 1'b0, 1'b1);
    idle(5);
    send_pkt(33, 100, 1'b1, 1'b1);
    wait_drain("overflow_drain", 400);

    // reset in the middle of an output burst
    send_pkt(0, 50, 1'b1, 1'b1);
    for (int k = 0; k < 20 && !dout_vld; k++) @(negedge clk);
    chk("rst_mid_started", 32'(dout_vld), 1);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", 32'({dout_vld, dout_sop, dout_eop, dout}), 0);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    idle(20);
    chk("rst_buffer_empty", 32'(dout_vld), 0);
    send_pkt(77, 25, 1'b1, 1'b1);
    wait_drain("post_rst_drain", 100);

    idle(5);
    chk("final_sb_empty", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
